// File: rtl/wb_arb_pkg.sv
// Shared defaults for the writeback port arbiter and its round-robin picker.
package wb_arb_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int GID_W          = $clog2(N_REQ_DEF);

endpackage : wb_arb_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, with wrap.
module rr_picker #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any_grant
);

  // Wrap by explicit compare so non-power-of-two N stays in 0..N-1.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !any_grant && req[wrap_add(ptr, k)]) begin
        grant[wrap_add(ptr, k)] = 1'b1;
        idx                     = wrap_add(ptr, k);
        any_grant               = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/wb_arb_en_reg.sv
// Enable-gated register primitive used to build the arbiter's output stage.
module wb_arb_en_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_aL,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)  q <= '0;
    else if (en)  q <= d;
  end

endmodule : wb_arb_en_reg

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among N_REQ writeback units.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit DROP_ZERO  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_aL,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          port_stall,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(N_REQ)-1:0]      grant_id
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       pick_idx;
  logic [N_REQ-1:0]      pick_grant;
  logic                  any_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [ID_W-1:0]       gid_d;

  // Gating with rst_aL keeps req_ready low for the whole reset window.
  rr_picker #(.N(N_REQ)) u_picker (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (!port_stall && rst_aL),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_grant (any_grant)
  );

  assign req_ready = pick_grant;
  assign sel_addr  = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)        ptr <= '0;
    else if (any_grant) ptr <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
  end

  // Address/data/id hold when idle; only wr_en drops, so the bank sees a clean pulse.
  always_comb begin
    en_d   = any_grant && !(DROP_ZERO && (sel_addr == '0));
    addr_d = any_grant ? sel_addr : wr_addr;
    data_d = any_grant ? sel_data : wr_data;
    gid_d  = any_grant ? pick_idx : grant_id;
  end

  wb_arb_en_reg #(.W(1)) u_en_q (
    .clk(clk), .rst_aL(rst_aL), .en(1'b1), .d(en_d), .q(wr_en)
  );
  wb_arb_en_reg #(.W(ADDR_WIDTH)) u_addr_q (
    .clk(clk), .rst_aL(rst_aL), .en(1'b1), .d(addr_d), .q(wr_addr)
  );
  wb_arb_en_reg #(.W(DATA_WIDTH)) u_data_q (
    .clk(clk), .rst_aL(rst_aL), .en(1'b1), .d(data_d), .q(wr_data)
  );
  wb_arb_en_reg #(.W(ID_W)) u_gid_q (
    .clk(clk), .rst_aL(rst_aL), .en(1'b1), .d(gid_d), .q(grant_id)
  );

endmodule : wb_port_arbiter

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares one register-bank write port among N_REQ writeback requesters (ALU, LSU, branch unit, …) with a fair round-robin policy and a registered output stage. It sits between the execute/writeback units and the architectural/physical register bank, which is built from enable-gated registers. Each requester uses a valid/ready handshake. The block drives a single write enable, address and data to the bank one cycle after acceptance.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: register data width.
- DROP_ZERO, 1: if 1, accepted writes to address 0 are consumed but never drive wr_en.

- clk  in  1  clock; all state updates on posedge.
- rst_aL  in  1  reset; asynchronous, active-low.
- req_valid  in  N_REQ  requester i has a write pending.
- req_addr  in  N_REQ*ADDR_WIDTH  requester i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  N_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_REQ  one-hot or zero; the request is accepted this cycle when req_valid[i] && req_ready[i].
- port_stall  in  1  the bank cannot take a write next cycle; no grants are issued.
- wr_en  out  1  registered write enable to the bank.
- wr_addr  out  ADDR_WIDTH  registered write address.
- wr_data  out  DATA_WIDTH  registered write data.
- grant_id  out  $clog2(N_REQ)  registered index of the requester whose write is on wr_*.

## Operation
- The state is the priority pointer ptr (0..N_REQ-1) plus the output stage (wr_en, wr_addr, wr_data, grant_id).
- Each cycle with port_stall=0, the arbiter searches req_valid from ptr upward with wrap-around (ptr, ptr+1, …, N_REQ-1, 0, …). The first valid requester g gets req_ready[g]=1.
- All other req_ready bits are 0. With port_stall=1 or no valid requester, req_ready=0.
- req_ready depends only on req_valid, ptr and port_stall. It never depends on addr or data.
- On acceptance of requester g:
  - ptr becomes (g+1) mod N_REQ; wrap uses explicit compare, not power-of-two masking.
  - The output stage loads wr_addr=req_addr[g], wr_data=req_data[g] and grant_id=g.
  - wr_en loads 1, unless DROP_ZERO=1 and the address is 0, in which case wr_en loads 0.
- With no acceptance, wr_en loads 0 and ptr holds. wr_addr, wr_data and grant_id hold their previous values.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not buffer unaccepted requests.
- Reset (rst_aL=0, any time): ptr=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0. An in-flight output write is discarded, and req_ready is 0 while reset is asserted.

## Timing
- Acceptance in cycle T puts the write on wr_* in cycle T+1. The bank captures it at the end of T+1. Latency is 1 cycle.
- Throughput is one write per cycle. Back-to-back grants to different requesters are allowed.
- A single requester that is always valid receives a grant every cycle, so ptr rotating past it does not block it.
- With all N_REQ valid continuously, each requester is granted exactly once per N_REQ cycles. The worst-case wait is N_REQ-1 cycles while port_stall=0.
- port_stall asserted in cycle T suppresses the grant in T, so wr_en=0 in T+1. A write already registered in T (accepted in T-1) still appears in T.
- When rst_aL deasserts, the first grant can occur in the first cycle after deassertion.

## Structure
- Shared package wb_arb_pkg holds the defaults for N_REQ, ADDR_WIDTH and DATA_WIDTH, and the localparam GID_W = $clog2(N_REQ).
- The sub-module rr_picker is purely combinational. Its inputs are req, ptr and en, and its outputs are the one-hot grant, the binary index and any_grant.
- The top level holds ptr and the output stage. The output registers are built from the team's enable-gated register primitive, with the enable tied high and the next-state value muxed.

## Test plan
- Reset with a request pending: assert rst_aL=0 mid-stream while req_valid=4'b1111 → req_ready=0, and wr_en=0, wr_addr=0, wr_data=0, grant_id=0 during reset. After release the first grant goes to requester 0.
- Full contention: req_valid=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3, with wr_en=1 in every cycle from the second on and grant_id matching the order delayed by one cycle.
- Sparse wrap: ptr=3, req_valid=4'b0011 → requester 0 is granted, then ptr=1. The next cycle grants requester 1.
- Stall: port_stall=1 for 2 cycles with req_valid=4'b0100 → req_ready=0 and wr_en=0. On release, requester 2 is granted with addr=7, data=32'hDEADBEEF, and wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF on the next cycle.
- Zero address with DROP_ZERO=1: requester 1 writes addr 0, data 32'h1234 → it is accepted (req_ready[1]=1) and ptr advances to 2, but wr_en=0 the next cycle.
- Single persistent requester: req_valid=4'b1000 for 4 cycles → a grant every cycle, 4 consecutive wr_en pulses, grant_id=3 throughout.
